eu_icon_read_arbiter: RTL and testbench

//  Shares one execution unit's operand-read port (eu_cache icon_raddr/rvalid/rdata/rsuccess) between N requesters (other EUs' operand fetch).

---
 rtl/eu_icon_read_arbiter_pkg.sv | 17 +
 rtl/eu_icon_read_arbiter_rr_priority_pick.sv | 28 ++
 rtl/eu_icon_read_arbiter.sv | 125 ++++++++++++
 tb/tb_eu_icon_read_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/eu_icon_read_arbiter_pkg.sv
// rtl/eu_icon_read_arbiter_pkg.sv - shared types for the EU operand-read arbiter
package eu_icon_read_arbiter_pkg;

  localparam int LOG2_NUM_EXEC_UNITS = 2;
  localparam int EU_ADDR_W           = 16;
  localparam int EU_DATA_W           = 32;

  typedef logic [EU_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EU_DATA_W-1:0] type_exec_unit_data;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } type_icon_rd_arb_state;

endpackage

// File: rtl/eu_icon_read_arbiter_rr_priority_pick.sv
// rtl/eu_icon_read_arbiter_rr_priority_pick.sv - combinational round-robin first-set-bit picker
module eu_icon_read_arbiter_rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_req
);

  // Scan rr_ptr, rr_ptr+1, ... wrapping by explicit compare so non-power-of-2 N works
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[PTR_W'(idx)]) begin
        any_req   = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/eu_icon_read_arbiter.sv
// rtl/eu_icon_read_arbiter.sv - round-robin, bounded-retry arbiter for one EU operand-read port
module eu_icon_read_arbiter
  import eu_icon_read_arbiter_pkg::*;
#(
  parameter int                             NUM_REQUESTERS = 4,
  parameter int                             MAX_RETRIES    = 3,
  parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX         = '0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQUESTERS-1:0]           req_valid_i,
  input  logic [NUM_REQUESTERS*EU_ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQUESTERS-1:0]           resp_valid_o,
  output logic [EU_DATA_W-1:0]                resp_data_o,
  output logic [EU_ADDR_W-1:0]                icon_tx_addr_o,
  output logic                                icon_tx_req_valid_o,
  input  logic [EU_DATA_W-1:0]                icon_tx_data_i,
  input  logic                                icon_tx_success_i
);

  localparam int PTR_W = $clog2(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(MAX_RETRIES + 1);

  type_icon_rd_arb_state state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]      retry_cnt_q, retry_cnt_d;
  type_exec_unit_addr    addr_q, addr_d;
  type_exec_unit_data    data_q, data_d;

  logic [PTR_W-1:0]      pick_idx;
  logic                  any_req;
  logic [PTR_W-1:0]      after_grant;

  eu_icon_read_arbiter_rr_priority_pick #(
    .N     (NUM_REQUESTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  // Pointer position just past the current grant, wrapping by compare
  assign after_grant = (grant_idx_q == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx_q + PTR_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      retry_cnt_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      retry_cnt_q <= retry_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Next-state: grant in IDLE, issue/retry/yield/abort in ISSUE, single-cycle response in RESP
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    retry_cnt_d = retry_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_idx_d = pick_idx;
          addr_d      = req_addr_i[int'(pick_idx)*EU_ADDR_W +: EU_ADDR_W];
          retry_cnt_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!req_valid_i[grant_idx_q]) begin
          // Requester withdrew: drop the read without moving the fairness pointer
          state_d = IDLE;
        end else if (icon_tx_success_i) begin
          data_d  = icon_tx_data_i;
          state_d = RESP;
        end else if (retry_cnt_q == CNT_W'(MAX_RETRIES - 1)) begin
          // Operand still not produced: yield so other requesters get the port
          rr_ptr_d = after_grant;
          state_d  = IDLE;
        end else begin
          retry_cnt_d = retry_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rr_ptr_d = after_grant;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    icon_tx_req_valid_o = (state_q == ISSUE);
    icon_tx_addr_o      = (state_q == ISSUE) ? addr_q : '0;
    resp_valid_o        = '0;
    resp_data_o         = '0;
    if (state_q == RESP) begin
      resp_valid_o = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << grant_idx_q;
      resp_data_o  = data_q;
    end
  end

  a_resp_onehot0 : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(resp_valid_o))
    else $error("eu_icon_read_arbiter[%0d]: multiple resp_valid bits %b", EU_IDX, resp_valid_o);

  a_tx_in_issue : assert property (@(posedge clk) disable iff (!reset_n) icon_tx_req_valid_o |-> (state_q == ISSUE))
    else $error("eu_icon_read_arbiter[%0d]: tx request outside ISSUE", EU_IDX);

endmodule

// File: tb/tb_eu_icon_read_arbiter.sv
// tb/tb_eu_icon_read_arbiter.sv - directed self-checking bench for eu_icon_read_arbiter
module tb_eu_icon_read_arbiter;

  localparam int N        = 4;
  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam logic [AW-1:0] NEVER_ADDR = 16'h0020;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic [AW-1:0]   tx_addr;
  logic            tx_req_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_success;
  logic            fail_first;

  int vectors;
  int miscompares;

  eu_icon_read_arbiter #(
    .NUM_REQUESTERS (4),
    .MAX_RETRIES    (3),
    .EU_IDX         (2'b00)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid_i         (req_valid),
    .req_addr_i          (req_addr),
    .resp_valid_o        (resp_valid),
    .resp_data_o         (resp_data),
    .icon_tx_addr_o      (tx_addr),
    .icon_tx_req_valid_o (tx_req_valid),
    .icon_tx_data_i      (tx_data),
    .icon_tx_success_i   (tx_success)
  );

  // EU model: NEVER_ADDR always misses, fail_first forces a miss, data tags the address
  assign tx_success = tx_req_valid && (tx_addr != NEVER_ADDR) && !fail_first;
  assign tx_data    = {16'hDA7A, tx_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    req_addr[r*AW +: AW] = a;
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    fail_first  = 1'b0;

    #3;
    chk("reset_tx_valid", 32'(tx_req_valid), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_tx_addr", 32'(tx_addr), 32'd0);
    #9;
    reset_n = 1'b1;
    step();

    // 1: single request
    set_addr(1, 16'h0015);
    req_valid = 4'b0010;
    step();
    chk("t1_tx_valid", 32'(tx_req_valid), 32'd1);
    chk("t1_tx_addr", 32'(tx_addr), 32'h15);
    chk("t1_no_early_resp", 32'(resp_valid), 32'd0);
    step();
    chk("t1_resp_valid", 32'(resp_valid), 32'b0010);
    chk("t1_resp_data", resp_data, 32'hDA7A0015);
    req_valid = '0;
    step();
    chk("t1_resp_gone", 32'(resp_valid), 32'd0);
    chk("t1_data_zero", resp_data, 32'd0);
    chk("t1_tx_idle", 32'(tx_req_valid), 32'd0);

    // 2: four requesters, always success, grant order 0,1,2,3,0
    pulse_reset();
    for (int r = 0; r < N; r++) set_addr(r, 16'(16'h0010 + r));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % N;
      if (k > 0) begin
        step();
        chk("t2_idle_gap_resp", 32'(resp_valid), 32'd0);
        chk("t2_idle_gap_tx", 32'(tx_req_valid), 32'd0);
      end
      step();
      chk("t2_issue_addr", 32'(tx_addr), 32'(16'h0010 + g));
      step();
      chk("t2_resp_valid", 32'(resp_valid), 32'(1 << g));
      chk("t2_resp_data", resp_data, 32'hDA7A0010 + 32'(g));
    end
    req_valid = '0;
    step();

    // 3: req0 never succeeds and yields after 3 tries, req1 served, req0 retried
    pulse_reset();
    set_addr(0, NEVER_ADDR);
    set_addr(1, 16'h0021);
    req_valid = 4'b0011;
    step();
    chk("t3_issue0_addr", 32'(tx_addr), 32'(NEVER_ADDR));
    step();
    chk("t3_retry1_tx", 32'(tx_req_valid), 32'd1);
    step();
    chk("t3_retry2_tx", 32'(tx_req_valid), 32'd1);
    chk("t3_retry2_addr", 32'(tx_addr), 32'(NEVER_ADDR));
    step();
    chk("t3_yield_tx", 32'(tx_req_valid), 32'd0);
    chk("t3_yield_resp", 32'(resp_valid), 32'd0);
    step();
    chk("t3_issue1_addr", 32'(tx_addr), 32'h21);
    step();
    chk("t3_resp1_valid", 32'(resp_valid), 32'b0010);
    chk("t3_resp1_data", resp_data, 32'hDA7A0021);
    req_valid = 4'b0001;
    step();
    step();
    chk("t3_req0_retried", 32'(tx_addr), 32'(NEVER_ADDR));

    // 5: drop the granted request mid-ISSUE -> abort, pointer kept at 2
    req_valid = '0;
    step();
    chk("t5_abort_tx", 32'(tx_req_valid), 32'd0);
    chk("t5_abort_resp", 32'(resp_valid), 32'd0);
    step();
    chk("t5_no_late_resp", 32'(resp_valid), 32'd0);
    set_addr(0, 16'h0030);
    req_valid = 4'b0011;
    step();
    chk("t5_ptr_kept_addr", 32'(tx_addr), 32'h30);
    step();
    chk("t5_resp_valid", 32'(resp_valid), 32'b0001);
    req_valid = '0;
    step();

    // 4: success on the second ISSUE cycle, then retry count restarts for the next grant
    pulse_reset();
    set_addr(2, 16'h0016);
    req_valid  = 4'b0100;
    fail_first = 1'b1;
    step();
    chk("t4_issue1_tx", 32'(tx_req_valid), 32'd1);
    step();
    chk("t4_issue2_tx", 32'(tx_req_valid), 32'd1);
    chk("t4_issue2_no_resp", 32'(resp_valid), 32'd0);
    fail_first = 1'b0;
    step();
    chk("t4_resp_valid", 32'(resp_valid), 32'b0100);
    chk("t4_resp_data", resp_data, 32'hDA7A0016);
    set_addr(3, NEVER_ADDR);
    req_valid = 4'b1000;
    step();
    step();
    step();
    step();
    chk("t4_third_try_tx", 32'(tx_req_valid), 32'd1);
    step();
    chk("t4_yield_tx", 32'(tx_req_valid), 32'd0);
    req_valid = '0;
    step();

    // 6: asynchronous reset mid-ISSUE
    pulse_reset();
    set_addr(1, 16'h0041);
    req_valid = 4'b0010;
    step();
    step();
    chk("t6_pre_resp", 32'(resp_valid), 32'b0010);
    req_valid = '0;
    step();
    set_addr(0, 16'h0040);
    set_addr(2, 16'h0042);
    req_valid  = 4'b0001;
    fail_first = 1'b1;
    step();
    chk("t6_in_issue", 32'(tx_req_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_tx", 32'(tx_req_valid), 32'd0);
    chk("t6_async_resp", 32'(resp_valid), 32'd0);
    chk("t6_async_addr", 32'(tx_addr), 32'd0);
    req_valid  = 4'b0111;
    fail_first = 1'b0;
    #2;
    reset_n = 1'b1;
    chk("t6_released_idle", 32'(tx_req_valid), 32'd0);
    step();
    chk("t6_ptr_zero_addr", 32'(tx_addr), 32'h40);
    step();
    chk("t6_resp_valid", 32'(resp_valid), 32'b0001);
    chk("t6_resp_data", resp_data, 32'hDA7A0040);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
